// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pkg
//  Purpose  : Shared constants for the branch predict unit: branch funct3
//             codes, 2-bit saturating counter encodings, reset counter value
//             and the counter update helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_RSV0 = 3'b010;
  localparam logic [2:0] F3_RSV1 = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = CTR_WNT;

  // funct3 010/011 are not branch conditions.
  function automatic logic f3_is_legal(input logic [2:0] f3);
    return !((f3 == F3_RSV0) || (f3 == F3_RSV1));
  endfunction

  // Saturating 2-bit counter step.
  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    logic [1:0] val;
    val = cur;
    if (taken) begin
      if (cur != CTR_ST) val = val + 2'd1;
    end else begin
      if (cur != CTR_SNT) val = val - 2'd1;
    end
    return ctr_t'(val);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_bht.sv
`default_nettype none
// ============================================================================
//  Module   : branch_bht
//  Purpose  : Branch history table of 2-bit saturating counters.
//  Ports    : clk, rst_n        - clock, synchronous active-low reset
//             rd_idx / rd_ctr   - asynchronous read port
//             wr_en, wr_idx,
//             wr_taken          - synchronous saturating-update port
//  Revision : 1.0  initial release
// ============================================================================
module branch_bht
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_t             rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  ctr_t table_q [BHT_ENTRIES];

  // Read returns the stored value; a same-cycle write is not bypassed.
  assign rd_ctr = table_q[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        table_q[i] <= CTR_RESET;
      end
    end else if (wr_en) begin
      table_q[wr_idx] <= ctr_next(table_q[wr_idx], wr_taken);
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predict_unit
//  Purpose  : Decode-stage bimodal prediction plus execute-stage branch
//             resolution, mispredict redirect and statistics.
//  Ports    : clk, rst_n                 - clock, synchronous active-low reset
//             dec_pc / dec_pred_taken    - prediction lookup
//             ex_valid, ex_branch, ex_jal, ex_jalr, ex_funct3, ex_rs1, ex_rs2,
//             ex_pc, ex_target, ex_pred_taken - resolving instruction
//             pc_src                     - combinational actual-taken
//             flush, flush_pc            - registered redirect
//             illegal_br                 - registered illegal-funct3 flag
//             br_count, mispred_count    - wrapping statistics
//  Revision : 1.0  initial release
// ============================================================================
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] dec_pc,
  output logic            dec_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            pc_src,
  output logic            flush,
  output logic [XLEN-1:0] flush_pc,
  output logic            illegal_br,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0] dec_idx;
  logic [IDX_W-1:0] ex_idx;
  ctr_t             dec_ctr;
  logic             cond;
  logic             legal;
  logic             br_upd;
  logic             br_illegal;
  logic             mispred;
  logic             flush_q;
  logic [XLEN-1:0]  flush_pc_q;
  logic             illegal_q;
  logic [31:0]      br_count_q;
  logic [31:0]      mispred_count_q;
  logic             unused_dec_bits;

  assign dec_idx = dec_pc[IDX_W+1:2];
  assign ex_idx  = ex_pc[IDX_W+1:2];
  assign unused_dec_bits = ^{dec_pc[XLEN-1:IDX_W+2], dec_pc[1:0]};

  branch_bht #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (dec_idx),
    .rd_ctr   (dec_ctr),
    .wr_en    (br_upd),
    .wr_idx   (ex_idx),
    .wr_taken (cond)
  );

  assign dec_pred_taken = dec_ctr[1];

  // Full-width comparisons; no reliance on a subtraction sign bit.
  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      F3_BEQ:  cond = (ex_rs1 == ex_rs2);
      F3_BNE:  cond = (ex_rs1 != ex_rs2);
      F3_BLT:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
      F3_BGE:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
      F3_BLTU: cond = (ex_rs1 <  ex_rs2);
      F3_BGEU: cond = (ex_rs1 >= ex_rs2);
      default: cond = 1'b0;
    endcase
  end

  assign legal      = f3_is_legal(ex_funct3);
  assign br_upd     = ex_valid & ex_branch & legal;
  assign br_illegal = ex_valid & ex_branch & ~legal;
  assign pc_src     = ex_valid & (ex_jal | ex_jalr | (ex_branch & cond));

  // Illegal branches are excluded so they never redirect or count.
  assign mispred = ex_valid & ((ex_branch & legal & (cond != ex_pred_taken)) |
                               (ex_jal & ~ex_pred_taken) |
                               ex_jalr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_q         <= 1'b0;
      flush_pc_q      <= '0;
      illegal_q       <= 1'b0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      flush_q   <= mispred;
      illegal_q <= br_illegal;
      if (mispred) begin
        flush_pc_q      <= pc_src ? ex_target : (ex_pc + XLEN'(4));
        mispred_count_q <= mispred_count_q + 32'd1;
      end
      if (br_upd) begin
        br_count_q <= br_count_q + 32'd1;
      end
    end
  end

  assign flush         = flush_q;
  assign flush_pc      = flush_pc_q;
  assign illegal_br    = illegal_q;
  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predict_unit
//  Purpose  : Self-checking bench for branch_predict_unit with a reference
//             model and an expected-result queue.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dec_pc = '0;
  logic        dec_pred_taken;
  logic        ex_valid = 1'b0;
  logic        ex_branch = 1'b0;
  logic        ex_jal = 1'b0;
  logic        ex_jalr = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_rs1 = '0;
  logic [31:0] ex_rs2 = '0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic        pc_src;
  logic        flush;
  logic [31:0] flush_pc;
  logic        illegal_br;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dec_pc         (dec_pc),
    .dec_pred_taken (dec_pred_taken),
    .ex_valid       (ex_valid),
    .ex_branch      (ex_branch),
    .ex_jal         (ex_jal),
    .ex_jalr        (ex_jalr),
    .ex_funct3      (ex_funct3),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .pc_src         (pc_src),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .illegal_br     (illegal_br),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  always #5 clk = ~clk;

  localparam int K_BR   = 0;
  localparam int K_JAL  = 1;
  localparam int K_JALR = 2;

  typedef struct {
    logic        flush;
    logic [31:0] fpc;
    logic        ill;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t        sb_q[$];
  logic [1:0]  m_bht [16];
  logic [31:0] m_fpc;
  logic [31:0] m_bc;
  logic [31:0] m_mc;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
    m_fpc = '0;
    m_bc  = '0;
    m_mc  = '0;
  endtask

  // Drive one execute-stage instruction (dec_pc aliases ex_pc so the same
  // index is looked up and updated in one cycle), check combinational
  // outputs, then check the registered results on the following edge.
  task automatic exec(input logic v, input int k, input logic [2:0] f3,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] pc, input logic [31:0] tgt,
                      input logic pred);
    logic       legal, c, act_t, mis, ill, slt;
    int         idx;
    exp_t       e;
    exp_t       got;
    @(negedge clk);
    ex_valid = v; ex_branch = (k == K_BR); ex_jal = (k == K_JAL); ex_jalr = (k == K_JALR);
    ex_funct3 = f3; ex_rs1 = rs1; ex_rs2 = rs2; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = pred; dec_pc = pc;
    #1;
    idx   = int'(pc[5:2]);
    legal = (f3 != 3'b010) && (f3 != 3'b011);
    slt   = (rs1[31] != rs2[31]) ? rs1[31] : (rs1 < rs2);
    case (f3)
      3'b000:  c = (rs1 == rs2);
      3'b001:  c = (rs1 != rs2);
      3'b100:  c = slt;
      3'b101:  c = !slt;
      3'b110:  c = (rs1 < rs2);
      3'b111:  c = !(rs1 < rs2);
      default: c = 1'b0;
    endcase
    act_t = v && ((k == K_BR) ? c : 1'b1);
    mis   = v && (((k == K_BR) && legal && (c != pred)) ||
                  ((k == K_JAL) && !pred) || (k == K_JALR));
    ill   = v && (k == K_BR) && !legal;
    chk("pc_src", {31'd0, pc_src}, {31'd0, act_t});
    chk("pred_lookup", {31'd0, dec_pred_taken}, {31'd0, m_bht[idx][1]});
    if (!rst_n) begin
      model_reset();
      e.flush = 1'b0;
      e.ill   = 1'b0;
    end else begin
      if (v && (k == K_BR) && legal) begin
        m_bc = m_bc + 1;
        if (c && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'd1;
        else if (!c && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'd1;
      end
      if (mis) begin
        m_mc  = m_mc + 1;
        m_fpc = act_t ? tgt : pc + 32'd4;
      end
      e.flush = mis;
      e.ill   = ill;
    end
    e.fpc = m_fpc;
    e.bc  = m_bc;
    e.mc  = m_mc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk("flush", {31'd0, flush}, {31'd0, got.flush});
    chk("flush_pc", flush_pc, got.fpc);
    chk("illegal_br", {31'd0, illegal_br}, {31'd0, got.ill});
    chk("br_count", br_count, got.bc);
    chk("mispred_count", mispred_count, got.mc);
    ex_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    // reset state
    exec(0, K_BR, 3'b000, 0, 0, 32'h100, 0, 0);
    rst_n = 1'b1;
    exec(0, K_BR, 3'b000, 0, 0, 32'h100, 0, 0);

    // beq taken with not-taken prediction -> redirect to target, counter 01->10
    exec(1, K_BR, 3'b000, 5, 5, 32'h100, 32'h200, 0);
    exec(0, K_BR, 3'b000, 0, 0, 32'h100, 0, 0);

    // saturate at 11, then step back down
    for (int i = 0; i < 5; i++) exec(1, K_BR, 3'b000, 7, 7, 32'h104, 32'h180, 1);
    exec(1, K_BR, 3'b001, 7, 7, 32'h104, 32'h180, 1);
    exec(0, K_BR, 3'b000, 0, 0, 32'h104, 0, 0);
    exec(1, K_BR, 3'b001, 7, 7, 32'h104, 32'h180, 1);
    exec(0, K_BR, 3'b000, 0, 0, 32'h104, 0, 0);

    // signed / unsigned conditions
    exec(1, K_BR, 3'b100, 32'hFFFF_FFFF, 1, 32'h108, 32'h300, 0);
    exec(1, K_BR, 3'b110, 32'hFFFF_FFFF, 1, 32'h108, 32'h300, 0);
    exec(1, K_BR, 3'b111, 0, 0, 32'h108, 32'h300, 0);
    exec(1, K_BR, 3'b101, 1, 32'hFFFF_FFFF, 32'h108, 32'h300, 1);
    exec(1, K_BR, 3'b110, 1, 32'hFFFF_FFFF, 32'h108, 32'h300, 1);
    exec(1, K_BR, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h108, 32'h300, 1);
    exec(1, K_BR, 3'b000, 1, 2, 32'h10C, 32'h300, 1);

    // jumps
    exec(1, K_JALR, 3'b000, 0, 0, 32'h110, 32'h400, 1);
    exec(0, K_BR, 3'b000, 0, 0, 32'h110, 0, 0);
    exec(1, K_JAL, 3'b000, 0, 0, 32'h114, 32'h500, 0);
    exec(1, K_JAL, 3'b000, 0, 0, 32'h114, 32'h500, 1);

    // illegal funct3, invalid instruction, wrapping fall-through address
    exec(1, K_BR, 3'b011, 3, 3, 32'h118, 32'h600, 1);
    exec(1, K_BR, 3'b010, 3, 4, 32'h118, 32'h600, 0);
    exec(0, K_BR, 3'b000, 1, 2, 32'h118, 32'h600, 1);
    exec(1, K_BR, 3'b001, 9, 9, 32'hFFFF_FFFC, 32'h700, 1);

    // mispredict counter wrap
    force dut.mispred_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.mispred_count_q;
    m_mc = 32'hFFFF_FFFF;
    exec(1, K_JALR, 3'b000, 0, 0, 32'h11C, 32'h800, 0);

    // reset overrides a mispredicting branch
    rst_n = 1'b0;
    exec(1, K_BR, 3'b000, 5, 5, 32'h100, 32'h200, 0);
    rst_n = 1'b1;
    exec(0, K_BR, 3'b000, 0, 0, 32'h100, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
